uart_tx_fifo: RTL and testbench

//  Byte buffer and transmit sequencer directly upstream of the UART transmitter.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_fifo_mem.sv | 27 ++
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 tb/tb_uart_tx_fifo.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and defaults used by the transmit queue, transmitter and receiver.
package uart_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int TXQ_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT
    } txq_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register array for the transmit queue: one write port, asynchronous head read, no reset on contents.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = TXQ_DEPTH_DEF,
    parameter int DATA_W = UART_DATA_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding the UART transmitter; issues one trmt pulse per byte and waits for tx_done.
//   state | meaning
//   IDLE  | queue empty or about to pop the head into tx_data
//   ISSUE | trmt high for this single cycle
//   GUARD | transmitter clearing tx_done; its value is not trusted yet
//   WAIT  | byte on the wire, leave when tx_done is seen high
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = TXQ_DEPTH_DEF,
    parameter int DATA_W = UART_DATA_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    level,
    output logic              ovf,
    input  logic              clr_ovf,
    output logic              trmt,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done,
    output logic              busy
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    txq_state_t        state;
    txq_state_t        state_nxt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [DATA_W-1:0] head;
    logic              pop;
    logic              push;
    logic              ovf_set;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign level = count;
    assign busy  = (state != IDLE);

    // A pop frees a slot on the same edge, so a push into a full queue is still taken then.
    assign pop     = (state == IDLE) && !empty;
    assign push    = wr_en && (!full || pop);
    assign ovf_set = wr_en && full && !pop;

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push && !rst),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = ISSUE;
            ISSUE:   state_nxt = GUARD;
            GUARD:   state_nxt = WAIT;
            WAIT:    if (tx_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            trmt    <= 1'b0;
            tx_data <= '0;
        end else begin
            state <= state_nxt;
            trmt  <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= head;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized bench for uart_tx_fifo with a behavioural transmitter and byte scoreboard.
module tb_uart_tx_fifo;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       wr_en   = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, ovf, trmt, busy;
    logic [3:0] level;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;

    int errors = 0;
    int checks = 0;

    // transmitter model knobs and state
    int done_n   = 10;
    bit late_clr = 1'b0;
    int cnt      = 0;
    bit running  = 1'b0;
    bit late_pending = 1'b0;

    logic [7:0] exp_q[$];
    int         pulses = 0;
    logic       prev_trmt = 1'b0;
    logic [7:0] last_tx = 8'h00;

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .ovf     (ovf),
        .clr_ovf (clr_ovf),
        .trmt    (trmt),
        .tx_data (tx_data),
        .tx_done (tx_done),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // transmitter: clears tx_done on the edge sampling trmt (optionally one edge late),
    // raises it done_n+1 edges later and holds it high; not affected by the queue's reset
    always @(posedge clk) begin
        if (trmt) begin
            if (!late_clr) tx_done <= 1'b0;
            late_pending <= late_clr;
            cnt          <= done_n;
            running      <= 1'b1;
        end else begin
            if (late_pending) begin
                tx_done      <= 1'b0;
                late_pending <= 1'b0;
            end
            if (running) begin
                if (cnt == 0) begin
                    tx_done <= 1'b1;
                    running <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    // scoreboard: every trmt pulse must carry the oldest accepted byte
    always @(negedge clk) begin
        if (rst) begin
            last_tx = 8'h00;
        end else if (trmt) begin
            pulses++;
            check("trmt_one_cycle", 32'(prev_trmt), 0);
            check("trmt_after_done", {30'd0, running, late_pending}, 0);
            check("trmt_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
            last_tx = tx_data;
        end else if (busy) begin
            check("tx_data_stable", 32'(tx_data), 32'(last_tx));
        end
        prev_trmt = trmt;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] b, input bit acc);
        wr_en   = 1'b1;
        wr_data = b;
        if (acc) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (empty && !busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_drain"}, 32'(ok), 1);
    endtask

    initial begin
        bit ok;
        int n;
        int base;

        // reset, with wr_en held during reset
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        repeat (2) @(negedge clk);
        check("rst_full", 32'(full), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_level", 32'(level), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_trmt", 32'(trmt), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_push_ignored", 32'(level), 0);
        check("rst_idle_no_trmt", 32'(pulses), 0);

        // single byte latency
        done_n = 12;
        push(8'hA5, 1'b1);
        check("a5_level", 32'(level), 1);
        check("a5_trmt_early", 32'(trmt), 0);
        check("a5_busy_early", 32'(busy), 0);
        @(negedge clk);
        check("a5_trmt", 32'(trmt), 1);
        check("a5_data", 32'(tx_data), 32'h A5);
        check("a5_busy", 32'(busy), 1);
        check("a5_level_popped", 32'(level), 0);
        @(negedge clk);
        check("a5_trmt_len", 32'(trmt), 0);
        drain("a5");
        check("a5_pulses", 32'(pulses), 1);

        // back-to-back pushes; first byte pops on the second push edge
        done_n = 8;
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        check("b2b_level", 32'(level), 2);
        drain("b2b");
        check("b2b_level_end", 32'(level), 0);
        check("b2b_pulses", 32'(pulses), 4);

        // fill during WAIT, overflow, clr_ovf, set-wins
        done_n = 40;
        push(8'h40, 1'b1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) push(8'($urandom), 1'b1);
        check("fill_level", 32'(level), 8);
        check("fill_full", 32'(full), 1);
        check("fill_ovf", 32'(ovf), 0);
        check("fill_busy", 32'(busy), 1);
        push(8'h99, 1'b0);
        check("ovf_set", 32'(ovf), 1);
        check("ovf_level", 32'(level), 8);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_clr", 32'(ovf), 0);
        wr_en   = 1'b1;
        wr_data = 8'h99;
        clr_ovf = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        check("ovf_set_wins", 32'(ovf), 1);
        check("ovf_level2", 32'(level), 8);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_clr2", 32'(ovf), 0);

        // push on the pop cycle of a full queue
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy && full) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("pop_window", 32'(ok), 1);
        if (ok) begin
            push(8'h77, 1'b1);
            check("pop_push_level", 32'(level), 8);
            check("pop_push_full", 32'(full), 1);
            check("pop_push_ovf", 32'(ovf), 0);
        end
        drain("full");

        // tx_done still high while ISSUE/GUARD
        late_clr = 1'b1;
        done_n   = 5;
        base     = pulses;
        for (int i = 0; i < 3; i++) push(8'($urandom), 1'b1);
        drain("late");
        check("late_pulses", 32'(pulses - base), 3);
        late_clr = 1'b0;

        // randomized bursts, never more than DEPTH outstanding
        for (int r = 0; r < 5; r++) begin
            n      = $urandom_range(8, 1);
            done_n = $urandom_range(20, 0);
            base   = pulses;
            for (int k = 0; k < n; k++) begin
                push(8'($urandom), 1'b1);
                repeat ($urandom_range(3, 0)) @(negedge clk);
            end
            drain("rand");
            check("rand_pulses", 32'(pulses - base), 32'(n));
        end

        // reset during WAIT with level 5
        done_n = 60;
        for (int i = 0; i < 6; i++) push(8'($urandom), 1'b1);
        check("mid_level", 32'(level), 5);
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_trmt", 32'(trmt), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_busy", 32'(busy), 0);
        exp_q.delete();
        base = pulses;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_no_pulses", 32'(pulses - base), 0);
        check("mid_still_empty", 32'(empty), 1);
        push(8'h5A, 1'b1);
        drain("post_rst");
        check("post_rst_pulses", 32'(pulses - base), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
